// File: rtl/ram8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram8_pkg
//  Description : Shared types and defaults for the 8-word RAM copy/fill engine.
//  Revision    : 1.0  initial release
// ============================================================================
package ram8_pkg;

    // Size of the addressed RAM in words; the address width follows from it
    localparam int MAX_WORDS      = 8;
    localparam int ADDR_W_DEFAULT = $clog2(MAX_WORDS);
    localparam int DATA_W_DEFAULT = 16;

    // Engine states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_FILL  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ram8_copier.sv
`default_nettype none
// ============================================================================
//  Module      : ram8_copier
//  Description : Copies or fills up to 2**ADDR_W words of a small RAM with
//                address wrap-around. Copy alternates READ/WRITE per word,
//                fill writes one word per cycle. RAM-side outputs are decoded
//                purely from registered state so there is no path from start
//                or ram_out to the RAM controls.
//  Revision    : 1.0  initial release
// ============================================================================
module ram8_copier
    import ram8_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);

    // Largest word count the RAM can hold; longer requests saturate to it
    localparam logic [ADDR_W:0] C_MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] C_ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   i_q, i_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [ADDR_W:0]   eff_len;
    logic [ADDR_W:0]   i_inc;

    assign eff_len = (length > C_MAX_LEN) ? C_MAX_LEN : length;
    assign i_inc   = i_q + C_ONE;

    // RAM-side outputs and status decoded from registered state only
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        ram_load    = 1'b0;
        ram_address = '0;
        ram_in      = '0;
        case (state_q)
            ST_READ: begin
                busy        = 1'b1;
                ram_address = src_q + i_q[ADDR_W-1:0];
            end
            ST_WRITE: begin
                busy        = 1'b1;
                ram_load    = 1'b1;
                ram_address = dst_q + i_q[ADDR_W-1:0];
                ram_in      = data_q;
            end
            ST_FILL: begin
                busy        = 1'b1;
                ram_load    = 1'b1;
                ram_address = dst_q + i_q[ADDR_W-1:0];
                ram_in      = fill_q;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Next-state logic: request capture, word stepping and completion
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        len_d   = len_q;
        src_d   = src_q;
        dst_d   = dst_q;
        fill_d  = fill_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    len_d  = eff_len;
                    fill_d = fill_value;
                    i_d    = '0;
                    if (eff_len == '0) begin
                        state_d = ST_DONE;
                    end else if (op) begin
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                data_d  = ram_out;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                i_d     = i_inc;
                state_d = (i_inc < len_q) ? ST_READ : ST_DONE;
            end
            ST_FILL: begin
                i_d     = i_inc;
                state_d = (i_inc < len_q) ? ST_FILL : ST_DONE;
            end
            ST_DONE: begin
                i_d     = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            len_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            fill_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            len_q   <= len_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram8_copier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram8_copier
//  Description : Self-checking bench for ram8_copier with a behavioural RAM
//                and a word-level reference model of copy/fill results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram8_copier;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        op;
    logic [2:0]  src_addr;
    logic [2:0]  dst_addr;
    logic [3:0]  length;
    logic [15:0] fill_value;
    logic        busy;
    logic        done;
    logic [2:0]  ram_address;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [15:0] ram_out;

    // Behavioural RAM plus a backdoor write port for preloading
    logic [15:0] mem [8];
    logic        bd_we;
    logic [2:0]  bd_addr;
    logic [15:0] bd_data;

    // Reference image of the RAM
    logic [15:0] ref_mem [8];

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    assign ram_out = mem[ram_address];

    always @(posedge clock) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_load) mem[ram_address] <= ram_in;
    end

    ram8_copier #(.DATA_W(16), .ADDR_W(3)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .op         (op),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .ram_address(ram_address),
        .ram_in     (ram_in),
        .ram_load   (ram_load),
        .ram_out    (ram_out)
    );

    // Reference model: sequential ascending copy/fill of min(len,8) words
    function automatic void model_apply(input bit o, input int s, input int d,
                                        input int l, input logic [15:0] f);
        int n = (l > 8) ? 8 : l;
        for (int k = 0; k < n; k++) begin
            if (o) ref_mem[(d + k) % 8] = f;
            else   ref_mem[(d + k) % 8] = ref_mem[(s + k) % 8];
        end
    endfunction

    function automatic int model_latency(input bit o, input int l);
        int n = (l > 8) ? 8 : l;
        if (n == 0) return 1;
        return o ? (n + 1) : (2 * n + 1);
    endfunction

    function automatic int model_words(input int l);
        return (l > 8) ? 8 : l;
    endfunction

    // Backdoor write of one word; called and returns at a falling edge
    task automatic write_word(input int k, input logic [15:0] v);
        bd_we   = 1'b1;
        bd_addr = 3'(k);
        bd_data = v;
        @(negedge clock);
        bd_we   = 1'b0;
        ref_mem[k] = v;
    endtask

    // Issues one request from IDLE and observes it until done (bounded)
    task automatic run_op(input bit o, input int s, input int d, input int l,
                          input logic [15:0] f, input bit hold, input bit noise,
                          output int done_cyc, output int busy_bad,
                          output int loads, output bit busy_at_done);
        int cyc;
        start      = 1'b1;
        op         = o;
        src_addr   = 3'(s);
        dst_addr   = 3'(d);
        length     = 4'(l);
        fill_value = f;
        @(posedge clock);
        cyc          = 0;
        done_cyc     = -1;
        busy_bad     = 0;
        loads        = 0;
        busy_at_done = 1'b1;
        while (done_cyc < 0 && cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (ram_load) loads++;
            if (done) begin
                done_cyc     = cyc;
                busy_at_done = busy;
            end else if (!busy) begin
                busy_bad++;
            end
            if (hold) begin
                start = 1'b1;
            end else if (noise && !done) begin
                start      = ($urandom_range(0, 1) == 1) || (cyc == 2);
                op         = 1'($urandom);
                src_addr   = 3'($urandom);
                dst_addr   = 3'($urandom);
                length     = 4'($urandom);
                fill_value = 16'($urandom);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        start      = 1'b0;
        op         = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        length     = '0;
        fill_value = '0;
        bd_we      = 1'b0;
        bd_addr    = '0;
        bd_data    = '0;
        repeat (3) @(negedge clock);
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (ram_load !== 1'b0)  begin failures++; $display("FAIL reset_load: got %b expected 0", ram_load); end
        checks++; if (ram_address !== 3'd0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", ram_address); end
        checks++; if (ram_in !== 16'd0)   begin failures++; $display("FAIL reset_in: got %h expected 0", ram_in); end
        for (int k = 0; k < 8; k++) write_word(k, 16'h1000 + 16'(k));
    endtask

    // Reset is released and start raised together: first edge must accept it
    task automatic test_copy();
        int dc, bb, ld; bit bad;
        reset_n = 1'b1;
        run_op(1'b0, 0, 4, 4, 16'h0, 1'b0, 1'b0, dc, bb, ld, bad);
        model_apply(1'b0, 0, 4, 4, 16'h0);
        checks++; if (dc !== 9)  begin failures++; $display("FAIL copy_latency: got %0d expected 9", dc); end
        checks++; if (bb !== 0)  begin failures++; $display("FAIL copy_busy: %0d non-busy cycles, expected 0", bb); end
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL copy_busy_at_done: got %b expected 0", bad); end
        checks++; if (ld !== 4)  begin failures++; $display("FAIL copy_loads: got %0d expected 4", ld); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (mem[k] !== ref_mem[k]) begin failures++; $display("FAIL copy_mem[%0d]: got %h expected %h", k, mem[k], ref_mem[k]); end
        end
        for (int k = 4; k < 8; k++) begin
            checks++; if (mem[k] !== 16'h1000 + 16'(k - 4)) begin failures++; $display("FAIL copy_word[%0d]: got %h expected %h", k, mem[k], 16'h1000 + 16'(k - 4)); end
        end
    endtask

    task automatic test_fill_wrap();
        int dc, bb, ld; bit bad;
        @(negedge clock);
        run_op(1'b1, int'($urandom_range(0, 7)), 6, 3, 16'hBEEF, 1'b0, 1'b0, dc, bb, ld, bad);
        model_apply(1'b1, 0, 6, 3, 16'hBEEF);
        checks++; if (dc !== model_latency(1'b1, 3)) begin failures++; $display("FAIL fill_latency: got %0d expected %0d", dc, model_latency(1'b1, 3)); end
        checks++; if (bb !== 0) begin failures++; $display("FAIL fill_busy: %0d non-busy cycles, expected 0", bb); end
        checks++; if (ld !== 3) begin failures++; $display("FAIL fill_loads: got %0d expected 3", ld); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (mem[k] !== ref_mem[k]) begin failures++; $display("FAIL fill_mem[%0d]: got %h expected %h", k, mem[k], ref_mem[k]); end
        end
    endtask

    task automatic test_boundary();
        int dc, bb, ld, s, d; bit bad;
        @(negedge clock);
        run_op(1'b0, 1, 2, 0, 16'h0, 1'b0, 1'b0, dc, bb, ld, bad);
        checks++; if (dc !== 1) begin failures++; $display("FAIL len0_latency: got %0d expected 1", dc); end
        checks++; if (ld !== 0) begin failures++; $display("FAIL len0_loads: got %0d expected 0", ld); end
        s = int'($urandom_range(0, 7));
        d = int'($urandom_range(0, 7));
        @(negedge clock);
        run_op(1'b0, s, d, 12, 16'h0, 1'b0, 1'b0, dc, bb, ld, bad);
        model_apply(1'b0, s, d, 8, 16'h0);
        checks++; if (dc !== 17) begin failures++; $display("FAIL len12_latency: got %0d expected 17", dc); end
        checks++; if (ld !== 8)  begin failures++; $display("FAIL len12_loads: got %0d expected 8", ld); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (mem[k] !== ref_mem[k]) begin failures++; $display("FAIL len12_mem[%0d]: got %h expected %h", k, mem[k], ref_mem[k]); end
        end
    endtask

    // Overlapping copy while start and request inputs toggle mid-operation
    task automatic test_overlap();
        int dc, bb, ld; bit bad;
        @(negedge clock);
        for (int k = 0; k < 8; k++) write_word(k, 16'($urandom));
        write_word(0, 16'hA5A5);
        run_op(1'b0, 0, 1, 3, 16'h0, 1'b0, 1'b1, dc, bb, ld, bad);
        model_apply(1'b0, 0, 1, 3, 16'h0);
        checks++; if (dc !== 7) begin failures++; $display("FAIL overlap_latency: got %0d expected 7", dc); end
        checks++; if (ld !== 3) begin failures++; $display("FAIL overlap_loads: got %0d expected 3", ld); end
        for (int k = 1; k < 4; k++) begin
            checks++; if (mem[k] !== 16'hA5A5) begin failures++; $display("FAIL overlap_word[%0d]: got %h expected a5a5", k, mem[k]); end
        end
        for (int k = 0; k < 8; k++) begin
            checks++; if (mem[k] !== ref_mem[k]) begin failures++; $display("FAIL overlap_mem[%0d]: got %h expected %h", k, mem[k], ref_mem[k]); end
        end
    endtask

    task automatic test_reset_mid();
        int dc, bb, ld, pulses; bit bad;
        @(negedge clock);
        for (int k = 0; k < 8; k++) write_word(k, 16'h2000 + 16'($urandom_range(0, 255)));
        start = 1'b1; op = 1'b0; src_addr = 3'd1; dst_addr = 3'd5; length = 4'd4;
        @(posedge clock);
        @(negedge clock); start = 1'b0;          // READ word 0
        @(negedge clock);                        // WRITE word 0
        @(negedge clock);                        // READ word 1
        @(negedge clock);                        // WRITE word 1: abort here
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)        begin failures++; $display("FAIL rmid_done: got %b expected 0", done); end
        checks++; if (ram_load !== 1'b0)    begin failures++; $display("FAIL rmid_load: got %b expected 0", ram_load); end
        checks++; if (ram_address !== 3'd0) begin failures++; $display("FAIL rmid_addr: got %0d expected 0", ram_address); end
        checks++; if (ram_in !== 16'd0)     begin failures++; $display("FAIL rmid_in: got %h expected 0", ram_in); end
        ref_mem[5] = ref_mem[1];
        pulses = 0;
        repeat (2) begin @(negedge clock); if (done) pulses++; end
        reset_n = 1'b1;
        repeat (3) begin @(negedge clock); if (done || busy) pulses++; end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL rmid_no_done: got %0d done/busy cycles expected 0", pulses); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (mem[k] !== ref_mem[k]) begin failures++; $display("FAIL rmid_mem[%0d]: got %h expected %h", k, mem[k], ref_mem[k]); end
        end
        run_op(1'b1, 0, 2, 2, 16'h7E57, 1'b0, 1'b0, dc, bb, ld, bad);
        model_apply(1'b1, 0, 2, 2, 16'h7E57);
        checks++; if (dc !== 3) begin failures++; $display("FAIL rmid_restart_latency: got %0d expected 3", dc); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (mem[k] !== ref_mem[k]) begin failures++; $display("FAIL rmid_restart_mem[%0d]: got %h expected %h", k, mem[k], ref_mem[k]); end
        end
    endtask

    // start held high: ignored in DONE, accepted in the following IDLE
    task automatic test_back_to_back();
        int dc, bb, ld, cyc; bit bad;
        @(negedge clock);
        run_op(1'b0, 2, 5, 3, 16'h0, 1'b1, 1'b0, dc, bb, ld, bad);
        model_apply(1'b0, 2, 5, 3, 16'h0);
        checks++; if (dc !== 7) begin failures++; $display("FAIL b2b_first_latency: got %0d expected 7", dc); end
        @(negedge clock);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL b2b_idle_after_done: busy=%b done=%b expected 0 0", busy, done); end
        @(negedge clock);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept: busy=%b expected 1", busy); end
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin @(negedge clock); cyc++; end
        checks++; if (cyc !== model_latency(1'b0, 3)) begin failures++; $display("FAIL b2b_second_latency: got %0d expected %0d", cyc, model_latency(1'b0, 3)); end
        model_apply(1'b0, 2, 5, 3, 16'h0);
        for (int k = 0; k < 8; k++) begin
            checks++; if (mem[k] !== ref_mem[k]) begin failures++; $display("FAIL b2b_mem[%0d]: got %h expected %h", k, mem[k], ref_mem[k]); end
        end
    endtask

    task automatic test_random();
        int dc, bb, ld, s, d, l; bit o, bad; logic [15:0] f;
        @(negedge clock);
        for (int k = 0; k < 8; k++) write_word(k, 16'($urandom));
        for (int t = 0; t < 24; t++) begin
            o = 1'($urandom);
            s = int'($urandom_range(0, 7));
            d = int'($urandom_range(0, 7));
            l = int'($urandom_range(0, 15));
            f = 16'($urandom);
            @(negedge clock);
            run_op(o, s, d, l, f, 1'b0, 1'b1, dc, bb, ld, bad);
            model_apply(o, s, d, l, f);
            checks++; if (dc !== model_latency(o, l)) begin failures++; $display("FAIL rand%0d_latency: got %0d expected %0d", t, dc, model_latency(o, l)); end
            checks++; if (ld !== model_words(l)) begin failures++; $display("FAIL rand%0d_loads: got %0d expected %0d", t, ld, model_words(l)); end
            checks++; if (bb !== 0 || bad !== 1'b0) begin failures++; $display("FAIL rand%0d_busy: idle-cycles=%0d busy_at_done=%b expected 0 0", t, bb, bad); end
            for (int k = 0; k < 8; k++) begin
                checks++; if (mem[k] !== ref_mem[k]) begin failures++; $display("FAIL rand%0d_mem[%0d]: got %h expected %h", t, k, mem[k], ref_mem[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_fill_wrap();
        test_boundary();
        test_overlap();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ram8_copier.md
RAM8_COPIER -- requirements
Module: ram8_copier

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the word width of ram_in and ram_out.
REQ-002 Parameter ADDR_W, default 3, SHALL set the word-address width; the address space is 2**ADDR_W words (8).
REQ-003 clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 start  input  1  SHALL request an operation; it is sampled only in IDLE.
REQ-006 op  input  1  SHALL select the operation: 0 = copy, 1 = fill; sampled with start.
REQ-007 src_addr  input  ADDR_W  SHALL give the first source word for copy; sampled with start.
REQ-008 dst_addr  input  ADDR_W  SHALL give the first destination word; sampled with start.
REQ-009 length  input  ADDR_W+1  SHALL give the word count, 0..15; sampled with start.
REQ-010 fill_value  input  DATA_W  SHALL give the fill word; sampled with start.
REQ-011 busy  output  1  SHALL be high in the READ, WRITE and FILL states.
REQ-012 done  output  1  SHALL be a one-cycle completion pulse.
REQ-013 ram_address  output  ADDR_W  SHALL be the word address driven to the RAM.
REQ-014 ram_in  output  DATA_W  SHALL be the write data driven to the RAM.
REQ-015 ram_load  output  1  SHALL be the RAM write enable; the RAM writes ram_in on the next clock edge.
REQ-016 ram_out  input  DATA_W  SHALL be the RAM read data, a combinational function of ram_address.

Function
REQ-017 The FSM SHALL have the states IDLE, READ, WRITE, FILL and DONE.
REQ-018 IDLE with start=1 SHALL latch all sampled inputs and set word index i=0.
- Next state if the effective length is 0: DONE.
- Otherwise, op=0: READ; op=1: FILL.
REQ-019 A length of 9..15 SHALL saturate to an effective length of 8.
REQ-020 READ SHALL drive ram_address=(src+i) mod 8 and ram_load=0, and SHALL capture ram_out into a data register at the clock edge; the next state is WRITE.
REQ-021 WRITE SHALL drive ram_address=(dst+i) mod 8, ram_in=the data register and ram_load=1.
- It SHALL then increment i.
- Next state: READ if words remain, otherwise DONE.
REQ-022 FILL SHALL drive ram_address=(dst+i) mod 8, ram_in=the latched fill_value and ram_load=1, then increment i.
- It SHALL stay in FILL while words remain, otherwise go to DONE.
REQ-023 DONE SHALL assert done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-024 Latency from the start-sampling edge to the done cycle SHALL be:
- copy of N words: 2N+1 cycles;
- fill of N words: N+1 cycles;
- length 0: 1 cycle.
REQ-025 Address arithmetic SHALL wrap modulo 8 (for example, src=6 with N=3 reads words 6, 7, 0).
REQ-026 Words SHALL be processed in ascending i.
- For overlapping copy regions, the result SHALL be exactly that of a sequential ascending copy.
- Example: src=0, dst=1, N=3 propagates word 0 into words 1..3.
REQ-027 start SHALL be ignored outside IDLE.
- Changes to the sampled inputs during an operation SHALL have no effect.
REQ-028 start asserted in the DONE cycle SHALL be ignored; start asserted in the following IDLE cycle SHALL be accepted.
REQ-029 ram_load SHALL be 0 in IDLE, READ and DONE.
REQ-030 ram_address and ram_in SHALL be 0 in IDLE and DONE.

Reset
REQ-031 reset_n=0 SHALL immediately force the following, regardless of the clock:
- state=IDLE, i=0, data register=0;
- busy=0, done=0, ram_load=0, ram_address=0, ram_in=0.
REQ-032 Reset mid-operation SHALL abort with no further writes and no done pulse; words already written stay written.
REQ-033 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Structure
REQ-034 Package ram8_pkg SHALL hold the state enumeration, the DATA_W/ADDR_W defaults and MAX_WORDS=8.
REQ-035 The block SHALL be a single module with no sub-modules; the word counter and the address adders are inline.
REQ-036 ram_load, ram_address and ram_in SHALL be decoded from the registered state and counters only, with no path from start or ram_out.

Verification
REQ-037 Copy test:
- Stimulus: RAM preloaded with words[k]=0x1000+k; copy src=0, dst=4, length=4.
- Required: words 4..7 = 0x1000..0x1003; done in cycle 9; busy high in cycles 1..8.
REQ-038 Fill with wrap:
- Stimulus: fill dst=6, length=3, fill_value=0xBEEF.
- Required: words 6, 7, 0 = 0xBEEF; other words unchanged; done in cycle 4.
REQ-039 Boundary lengths:
- length=0 SHALL produce no ram_load and done in cycle 1.
- length=12 SHALL behave exactly as length=8 (done in cycle 17 for a copy).
REQ-040 Overlap and ignored start:
- Stimulus: copy src=0, dst=1, length=3 with word0=0xA5A5; a second start pulse is asserted mid-operation.
- Required: words 1..3 = 0xA5A5; the second start pulse is ignored.
REQ-041 Reset mid-operation:
- Stimulus: reset_n pulsed low during the second WRITE of a copy of length 4.
- Required: all outputs are 0 immediately; exactly one word has been written; no done pulse; a new start after reset completes normally.
